// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_e;

  // Wide enough for MEM_LAT up to 7.
  localparam int LAT_W = $clog2(8);

endpackage

// File: rtl/arb_rr2_pick.sv
// Combinational 2-way round-robin picker; force_hi hands ties to requester 1.
module arb_rr2_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_hi,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (force_hi || last == REQ_CPU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU and the loader; round-robin with a
// loader lock, and returns read data MEM_LAT cycles after the grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e       state;
  req_id_e          last_gnt;
  req_id_e          owner;
  logic [LAT_W-1:0] lat_cnt;

  logic [1:0] pick;
  logic       gnt_en;
  logic       any_gnt;
  logic       win_ldr;
  logic       sel_we;
  logic       rd_done;
  logic       rd_owner_ldr;

  arb_rr2_pick u_pick (
    .req      ({ldr_req, cpu_req}),
    .last     (last_gnt),
    .force_hi (ldr_lock),
    .gnt      (pick)
  );

  // Grants are gated by reset so every output is quiet while rst is high.
  always_comb begin
    gnt_en  = (state == IDLE) && !rst;
    cpu_gnt = gnt_en & pick[0];
    ldr_gnt = gnt_en & pick[1];
    any_gnt = cpu_gnt | ldr_gnt;
    win_ldr = ldr_gnt;
    sel_we  = win_ldr ? ldr_we : cpu_we;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (any_gnt) begin
      mem_addr  = win_ldr ? ldr_addr  : cpu_addr;
      mem_wdata = win_ldr ? ldr_wdata : cpu_wdata;
      mem_we    = sel_we;
      mem_re    = !sel_we;
    end
  end

  // Zero latency completes in the grant cycle; otherwise on the last wait cycle.
  always_comb begin
    rd_done      = 1'b0;
    rd_owner_ldr = 1'b0;
    if (MEM_LAT == 0) begin
      rd_done      = any_gnt && !sel_we;
      rd_owner_ldr = win_ldr;
    end else begin
      rd_done      = (state == RD_WAIT) && (lat_cnt == LAT_W'(1)) && !rst;
      rd_owner_ldr = (owner == REQ_LDR);
    end
    cpu_rvalid = rd_done && !rd_owner_ldr;
    ldr_rvalid = rd_done &&  rd_owner_ldr;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    ldr_rdata  = ldr_rvalid ? mem_rdata : '0;
  end

  assign busy = (state == RD_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= REQ_LDR;
      owner    <= REQ_CPU;
      lat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_gnt) begin
            last_gnt <= win_ldr ? REQ_LDR : REQ_CPU;
            if (!sel_we && MEM_LAT != 0) begin
              owner   <= win_ldr ? REQ_LDR : REQ_CPU;
              lat_cnt <= LAT_W'(MEM_LAT);
              state   <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: four arbiters (MEM_LAT 1,0,2,3) share stimulus; each test
// checks only the instance whose latency it targets.
module tb_mem_port_arbiter;

  localparam int NDUT = 4;
  localparam int D1 = 0, D0 = 1, D2 = 2, D3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0, ldr_lock = 0;
  logic [4:0] cpu_addr = 0, ldr_addr = 0;
  logic [7:0] cpu_wdata = 0, ldr_wdata = 0, mem_rdata = 0;

  logic [NDUT-1:0]      cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, mem_we, mem_re, busy;
  logic [NDUT-1:0][7:0] cpu_rdata, ldr_rdata, mem_wdata;
  logic [NDUT-1:0][4:0] mem_addr;

  genvar g;
  for (g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 2 : 3;
    mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(L)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt[g]),
      .cpu_rvalid (cpu_rvalid[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .ldr_req    (ldr_req),
      .ldr_we     (ldr_we),
      .ldr_addr   (ldr_addr),
      .ldr_wdata  (ldr_wdata),
      .ldr_lock   (ldr_lock),
      .ldr_gnt    (ldr_gnt[g]),
      .ldr_rvalid (ldr_rvalid[g]),
      .ldr_rdata  (ldr_rdata[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_we     (mem_we[g]),
      .mem_re     (mem_re[g]),
      .mem_rdata  (mem_rdata),
      .busy       (busy[g])
    );
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    nxt(); nxt();
    rst = 1'b0;
  endtask

  // Word of every output of one instance, for all-zero checks.
  function automatic logic [31:0] outs(input int d);
    return {cpu_gnt[d], cpu_rvalid[d], ldr_gnt[d], ldr_rvalid[d], mem_we[d], mem_re[d],
            busy[d], 1'b0, cpu_rdata[d], ldr_rdata[d], mem_wdata[d]} | 32'(mem_addr[d]);
  endfunction

  initial begin
    // Reset state with a live request: nothing may be granted while rst is high.
    idle_in();
    cpu_req = 1; ldr_req = 1; mem_rdata = 8'hFF;
    smp();
    for (int d = 0; d < NDUT; d++) chk($sformatf("rst_outs%0d", d), outs(d), 32'h0);
    do_reset();
    smp();
    for (int d = 0; d < NDUT; d++) chk($sformatf("post_rst_outs%0d", d), outs(d), 32'h0);

    // T1: MEM_LAT=1 CPU read addr 5.
    nxt();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5; mem_rdata = 8'hA5;
    smp();
    chk("t1_gnt",   cpu_gnt[D1], 1);
    chk("t1_re",    mem_re[D1], 1);
    chk("t1_addr",  mem_addr[D1], 5);
    chk("t1_busy0", busy[D1], 0);
    chk("t1_rv0",   cpu_rvalid[D1], 0);
    nxt(); cpu_req = 0;
    smp();
    chk("t1_rv1",   cpu_rvalid[D1], 1);
    chk("t1_rd1",   cpu_rdata[D1], 8'hA5);
    chk("t1_busy1", busy[D1], 1);
    chk("t1_gnt1",  cpu_gnt[D1], 0);
    chk("t1_ldrrv", ldr_rvalid[D1], 0);
    nxt();
    smp();
    chk("t1_busy2", busy[D1], 0);
    chk("t1_rv2",   cpu_rvalid[D1], 0);

    // T2: both writing, no lock, from reset: CPU, LDR, CPU, LDR.
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'd1; cpu_wdata = 8'h11;
    ldr_req = 1; ldr_we = 1; ldr_addr = 5'd2; ldr_wdata = 8'h22;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk($sformatf("t2_cg%0d", k), cpu_gnt[D1], (k % 2 == 0));
      chk($sformatf("t2_lg%0d", k), ldr_gnt[D1], (k % 2 == 1));
      chk($sformatf("t2_we%0d", k), mem_we[D1], 1);
      chk($sformatf("t2_re%0d", k), mem_re[D1], 0);
      chk($sformatf("t2_ad%0d", k), mem_addr[D1], (k % 2 == 0) ? 1 : 2);
      chk($sformatf("t2_wd%0d", k), mem_wdata[D1], (k % 2 == 0) ? 8'h11 : 8'h22);
      chk($sformatf("t2_rv%0d", k), cpu_rvalid[D1] | ldr_rvalid[D1], 0);
      nxt();
    end

    // T3: lock holds the loader for 3 cycles, then CPU wins the next tie.
    ldr_lock = 1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("t3_lg%0d", k), ldr_gnt[D1], 1);
      chk($sformatf("t3_cg%0d", k), cpu_gnt[D1], 0);
      nxt();
    end
    ldr_lock = 0;
    smp();
    chk("t3_unlock_cg", cpu_gnt[D1], 1);
    chk("t3_unlock_lg", ldr_gnt[D1], 0);
    // Lock with no loader request must not stall the CPU.
    nxt(); ldr_req = 0; ldr_lock = 1;
    smp();
    chk("t3_lock_idle_cg", cpu_gnt[D1], 1);
    nxt(); idle_in();

    // T4: MEM_LAT=3 loader read; CPU request waits out RD_WAIT.
    do_reset();
    ldr_req = 1; ldr_we = 0; ldr_addr = 5'd7; mem_rdata = 8'h5A;
    smp();
    chk("t4_lg", ldr_gnt[D3], 1);
    chk("t4_ad", mem_addr[D3], 7);
    nxt();
    ldr_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3;
    for (int k = 1; k <= 3; k++) begin
      smp();
      chk($sformatf("t4_cg%0d", k), cpu_gnt[D3], 0);
      chk($sformatf("t4_busy%0d", k), busy[D3], 1);
      chk($sformatf("t4_re%0d", k), mem_re[D3], 0);
      chk($sformatf("t4_lrv%0d", k), ldr_rvalid[D3], (k == 3));
      chk($sformatf("t4_lrd%0d", k), ldr_rdata[D3], (k == 3) ? 8'h5A : 8'h00);
      chk($sformatf("t4_crv%0d", k), cpu_rvalid[D3], 0);
      nxt();
    end
    smp();
    chk("t4_cg4",   cpu_gnt[D3], 1);
    chk("t4_busy4", busy[D3], 0);
    chk("t4_ad4",   mem_addr[D3], 3);
    nxt(); idle_in();

    // T5: MEM_LAT=0 read returns in the grant cycle.
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd2; mem_rdata = 8'h3C;
    smp();
    chk("t5_gnt",  cpu_gnt[D0], 1);
    chk("t5_rv",   cpu_rvalid[D0], 1);
    chk("t5_rd",   cpu_rdata[D0], 8'h3C);
    chk("t5_busy", busy[D0], 0);
    chk("t5_ad",   mem_addr[D0], 2);
    nxt(); cpu_req = 0;
    smp();
    chk("t5_busy1", busy[D0], 0);
    chk("t5_rv1",   cpu_rvalid[D0], 0);

    // T6: MEM_LAT=2 read aborted by reset.
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd9; mem_rdata = 8'h77;
    smp();
    chk("t6_gnt", cpu_gnt[D2], 1);
    nxt();
    cpu_req = 0; rst = 1;
    smp();
    chk("t6_rst_outs", outs(D2), 32'h0);
    nxt(); rst = 0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("t6_rv%0d", k), cpu_rvalid[D2] | ldr_rvalid[D2], 0);
      chk($sformatf("t6_busy%0d", k), busy[D2], 0);
      nxt();
    end
    cpu_req = 1; cpu_we = 1; ldr_req = 1; ldr_we = 1;
    smp();
    chk("t6_tie_cg", cpu_gnt[D2], 1);
    chk("t6_tie_lg", ldr_gnt[D2], 0);
    nxt(); idle_in();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
